// File: rtl/strip_pkg.sv
// Shared symbols, FSM states and slot arithmetic for the framing sequencer
// that feeds the byte striper.
package strip_pkg;

    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] IDL = 8'h7C;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StPayload,
        StPad,
        StEndt,
        StSkip
    } state_e;

    function automatic int unsigned slot_next(input int unsigned slot, input int unsigned lanes);
        return (slot >= lanes - 1) ? 0 : slot + 1;
    endfunction

endpackage

// File: rtl/strip_skp_timer.sv
// Saturating SKP interval counter; raises pending once the interval has elapsed
// and holds it until the sequencer enters a SKP row.
module strip_skp_timer #(
    parameter int unsigned SKP_INTERVAL = 64,
    parameter int unsigned SKP_CNT_W    = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic pending_o
);

    localparam logic [SKP_CNT_W-1:0] Interval = SKP_CNT_W'(SKP_INTERVAL);

    logic [SKP_CNT_W-1:0] cnt_q, cnt_d;
    logic                 pending_q, pending_d;

    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (clr_i) begin
            cnt_d     = '0;
            pending_d = 1'b0;
        end else begin
            if (cnt_q != Interval) begin
                cnt_d = cnt_q + SKP_CNT_W'(1);
            end
            if (cnt_d == Interval) begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/strip_frame_ctrl.sv
// Framing sequencer: turns link-layer packets into the lane-aligned D/DK stream
// consumed by the byte striper, with IDL padding and periodic COM/SKP rows.
module strip_frame_ctrl
    import strip_pkg::*;
#(
    parameter int unsigned LANES        = 4,
    parameter int unsigned BITS         = 8,
    parameter int unsigned SKP_INTERVAL = 64,
    parameter int unsigned SKP_CNT_W    = 8
) (
    input  logic                     CLK,
    input  logic                     RESET_L,
    input  logic [BITS-1:0]          IN_DATA,
    input  logic                     IN_VALID,
    input  logic                     IN_SOP,
    input  logic                     IN_EOP,
    input  logic                     IN_TYPE,
    input  logic                     IN_ERR,
    output logic                     IN_READY,
    output logic [BITS-1:0]          D,
    output logic                     DK,
    output logic [$clog2(LANES)-1:0] SLOT,
    output logic                     BUSY,
    output logic                     SKP_DONE
);

    localparam int unsigned SlotW = $clog2(LANES);
    localparam logic [SlotW-1:0] LastSlot = SlotW'(LANES - 1);
    localparam logic [SlotW-1:0] PadSlot  = SlotW'(LANES - 2);

    localparam logic [BITS-1:0] SymStp = BITS'(STP);
    localparam logic [BITS-1:0] SymSdp = BITS'(SDP);
    localparam logic [BITS-1:0] SymEnd = BITS'(END);
    localparam logic [BITS-1:0] SymEdb = BITS'(EDB);
    localparam logic [BITS-1:0] SymCom = BITS'(COM);
    localparam logic [BITS-1:0] SymSkp = BITS'(SKP);
    localparam logic [BITS-1:0] SymIdl = BITS'(IDL);

    state_e           state_q, state_d;
    logic [SlotW-1:0] slot_q, slot_d;
    logic [BITS-1:0]  d_q, d_d;
    logic             dk_q, dk_d;
    logic             busy_q, busy_d;
    logic             skp_done_q, skp_done_d;
    logic             err_q, err_d;
    logic             skp_clr;
    logic             skp_pending;

    strip_skp_timer #(
        .SKP_INTERVAL(SKP_INTERVAL),
        .SKP_CNT_W   (SKP_CNT_W)
    ) u_skp_timer (
        .clk_i    (CLK),
        .rst_ni   (RESET_L),
        .clr_i    (skp_clr),
        .pending_o(skp_pending)
    );

    // Each state computes the symbol registered for the next cycle, which lands on slot_d.
    always_comb begin
        slot_d     = SlotW'(slot_next(32'(slot_q), LANES));
        state_d    = state_q;
        d_d        = SymIdl;
        dk_d       = 1'b1;
        busy_d     = 1'b0;
        skp_done_d = 1'b0;
        err_d      = err_q;
        skp_clr    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Decide one cycle early so the opening symbol lands on slot 0.
                if (slot_d == LastSlot) begin
                    if (skp_pending) begin
                        state_d = StSkip;
                        skp_clr = 1'b1;
                    end else if (IN_VALID && IN_SOP) begin
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                d_d     = IN_TYPE ? SymSdp : SymStp;
                dk_d    = 1'b0;
                busy_d  = 1'b1;
                err_d   = IN_ERR;
                state_d = StPayload;
            end
            StPayload: begin
                busy_d = 1'b1;
                if (IN_VALID) begin
                    d_d   = IN_DATA;
                    err_d = err_q | IN_ERR;
                    if (IN_EOP) begin
                        state_d = (slot_d == PadSlot) ? StEndt : StPad;
                    end
                end
            end
            StPad: begin
                busy_d = 1'b1;
                if (slot_d == PadSlot) begin
                    state_d = StEndt;
                end
            end
            StEndt: begin
                d_d     = err_q ? SymEdb : SymEnd;
                dk_d    = 1'b0;
                busy_d  = 1'b1;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            StSkip: begin
                d_d = (slot_d == '0) ? SymCom : SymSkp;
                if (slot_d == LastSlot) begin
                    skp_done_d = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q    <= StIdle;
            slot_q     <= '0;
            d_q        <= SymIdl;
            dk_q       <= 1'b1;
            busy_q     <= 1'b0;
            skp_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            d_q        <= d_d;
            dk_q       <= dk_d;
            busy_q     <= busy_d;
            skp_done_q <= skp_done_d;
            err_q      <= err_d;
        end
    end

    assign IN_READY = (state_q == StPayload);
    assign D        = d_q;
    assign DK       = dk_q;
    assign SLOT     = slot_q;
    assign BUSY     = busy_q;
    assign SKP_DONE = skp_done_q;

endmodule

// File: doc/strip_frame_ctrl.md
Name: strip_frame_ctrl

Overview:
- Framing sequencer that sits directly upstream of the byte striper.
- Accepts packet bytes from the link layer over a valid/ready interface and produces the one-byte-per-clock D/DK stream the striper distributes round-robin across LANES lanes.
- Places STP/SDP on lane 0 and END/EDB on lane LANES-1, pads with IDL, and periodically inserts a lane-aligned COM/SKP row between packets.

Parameters:
- LANES, 4, number of striper lanes (>=2); SLOT counter wraps at LANES-1.
- BITS, 8, symbol width.
- SKP_INTERVAL, 64, output cycles between SKP row requests.
- SKP_CNT_W, 8, width of the SKP interval counter (must hold SKP_INTERVAL).

Ports:
- CLK  in  1  rising-edge clock, shared with the striper.
- RESET_L  in  1  asynchronous active-low reset.
- IN_DATA  in  BITS  packet byte.
- IN_VALID  in  1  IN_DATA valid.
- IN_SOP  in  1  first byte of packet (qualifies IN_VALID).
- IN_EOP  in  1  last byte of packet.
- IN_TYPE  in  1  0 = TLP (STP), 1 = DLLP (SDP); sampled with SOP.
- IN_ERR  in  1  nullify packet; sampled on any accepted byte.
- IN_READY  out  1  byte accepted when IN_VALID & IN_READY at posedge.
- D  out  BITS  symbol to striper.
- DK  out  1  0 = framing token (STP/SDP/END/EDB), 1 = everything else.
- SLOT  out  clog2(LANES)  lane index the current D occupies.
- BUSY  out  1  high from STP/SDP through END/EDB inclusive.
- SKP_DONE  out  1  one-cycle pulse on the last SKP of a row.

Behaviour:
- Constants: STP=8'hFB, SDP=8'h5C, END=8'hFD, EDB=8'hFE, COM=8'hBC, SKP=8'h1C, IDL=8'h7C.
- Reset (async, RESET_L=0):
  - D=IDL, DK=1, SLOT=0, BUSY=0, SKP_DONE=0, IN_READY=0.
  - State IDLE; SKP counter=0; pending=0; error latch=0.
  - Mid-packet reset abandons the packet silently.
- Outputs D/DK/SLOT/BUSY/SKP_DONE are registered. After reset SLOT counts 0,1,…,LANES-1,0 every cycle, unconditionally.
- IN_READY is combinational: high only in PAYLOAD. An accepted byte appears on D the next cycle with DK=1.
- States:
  - IDLE: emits IDL/DK=1. When the next slot is 0:
    - If SKP pending → SKIP.
    - Else if IN_VALID & IN_SOP → START.
    - IN_VALID without SOP in IDLE is ignored (not accepted).
  - START: emits STP (IN_TYPE=0) or SDP (IN_TYPE=1), DK=0, at SLOT 0. IN_TYPE and IN_ERR are latched → PAYLOAD.
  - PAYLOAD: each cycle emits the accepted byte.
    - If IN_VALID=0 (underrun), emits IDL/DK=1; the slot is still consumed.
    - On accepting a byte with IN_EOP: go to PAD, or directly to ENDT if that byte lands at SLOT LANES-2.
  - PAD: emits IDL/DK=1 until SLOT=LANES-2, then → ENDT.
    - If the EOP byte landed at SLOT LANES-1, a full padding row (slots 0..LANES-2) precedes END.
  - ENDT: emits END, or EDB if the error latch is set, DK=0, at SLOT LANES-1. Clears the latch → IDLE.
  - SKIP: emits COM at SLOT 0, then SKP at slots 1..LANES-1, all DK=1. SKP_DONE pulses with the final SKP → IDLE.
- SKP counter:
  - Increments every cycle and saturates at SKP_INTERVAL.
  - On reaching SKP_INTERVAL, sets pending.
  - Entering SKIP clears pending and the counter.
  - SKP is never inserted mid-packet. When SKP is pending and a SOP is waiting, SKP wins; the packet starts on the following slot 0.
- Edge cases:
  - SOP and EOP on the same byte: 1-byte payload, then padding rules apply.
  - A new SOP arriving while in PAYLOAD is treated as data.
- BUSY=1 for every cycle whose D is STP/SDP, payload, pad, or END/EDB.

Decomposition:
- Package strip_pkg:
  - The seven symbol constants.
  - A state enum: IDLE, START, PAYLOAD, PAD, ENDT, SKIP.
  - Function slot_next(slot, LANES).
- One sub-module: strip_skp_timer, holding the saturating counter and pending flag, with a clear input from SKIP entry.

Test Plan:
- Reset then idle, LANES=4: D=8'h7C, DK=1 for all cycles; SLOT sequence 0,1,2,3,0.
- TLP of 2 bytes AA,BB offered at SLOT 2: STP appears at the next SLOT 0; AA@1, BB@2, END(FD, DK=0)@3; IN_READY high exactly 2 cycles; BUSY high 4 cycles.
- DLLP of 3 bytes with IN_ERR on byte 2: SDP@0, bytes@1..3; full pad row IDL@0..2; EDB(FE)@3.
- Underrun: 4-byte TLP with IN_VALID low for 1 cycle after byte 1 → IDL inserted in payload; END lands at SLOT 3 of the second row.
- SKP_INTERVAL=8 with a continuous packet stream: SKP row (BC,1C,1C,1C at SLOT 0..3) appears only between END and the next STP; SKP_DONE pulses at SLOT 3.
- Reset asserted at payload byte 2: outputs return to IDL/DK=1/SLOT=0 immediately; after release, the next SOP produces a clean STP at SLOT 0.
